// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer in the reference-clock domain: pulses pll_rst, waits for a stable
// synchronized lock, then releases sys_rst. Optional macro PLL_AUTO_RELOCK_EN relocks after loss in RUN.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_fail,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync;
  logic             lock_s;

  assign lock_s = sync[1];

  // Sequencer; every output is updated on the same edge as the state transition it belongs to.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      sync      <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      lock_fail <= 1'b0;
    end else begin
      sync <= {sync[0], pll_locked};
      cnt  <= cnt + CNT_W'(1);
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          // Lock observed on the timeout cycle still counts as lock.
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (retry_cnt < RETRY_LIMIT) begin
              state     <= PLL_RST;
              retry_cnt <= retry_cnt + 4'd1;
              pll_rst   <= 1'b1;
            end else begin
              state     <= FAIL;
              lock_fail <= 1'b1;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst   <= 1'b0;
            retry_cnt <= '0;
          end
        end
        RUN: begin
          cnt <= '0;
          if (!lock_s) begin
            sys_rst <= 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
            state     <= PLL_RST;
            pll_rst   <= 1'b1;
            retry_cnt <= '0;
`else
            state     <= FAIL;
            lock_fail <= 1'b1;
`endif
          end
        end
        FAIL: begin
          cnt <= '0;
        end
        default: begin
          state     <= PLL_RST;
          cnt       <= '0;
          retry_cnt <= '0;
          pll_rst   <= 1'b1;
          sys_rst   <= 1'b1;
          lock_fail <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_fail;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (64),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .refclk    (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .lock_fail (lock_fail),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for 3 cycles; returns just after the last reset edge with rst already low.
  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
  endtask

  task automatic wait_pll_rst_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pll_rst === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_release(output int e);
    e = -1;
    for (int i = 0; i < 200; i++) begin
      if (sys_rst === 1'b0) begin
        e = cyc;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    int  n, k, j, e, rel, pulses, maxr, fe;
    bit  ok;
    logic prev;

    // Reset values
    do_reset();
    check("rst_pll_rst", 32'(pll_rst), 1);
    check("rst_sys_rst", 32'(sys_rst), 1);
    check("rst_lock_fail", 32'(lock_fail), 0);
    check("rst_retry_cnt", 32'(retry_cnt), 0);

    // Nominal lock: 4-cycle pll_rst, release 10 edges after first lock sample
    pulse_len(n);
    check("nom_pulse_len", 32'(n), 4);
    pll_locked = 1'b1;
    k = cyc + 1;
    check("nom_sys_rst_held", 32'(sys_rst), 1);
    wait_release(e);
    check("nom_release_edge", 32'(e - k), 10);
    check("nom_pll_rst_run", 32'(pll_rst), 0);
    check("nom_retry_run", 32'(retry_cnt), 0);

    // Loss of lock in RUN
    pll_locked = 1'b0;
    tick(2);
    check("loss_sys_rst_early", 32'(sys_rst), 0);
    tick(1);
    check("loss_sys_rst", 32'(sys_rst), 1);
`ifdef PLL_AUTO_RELOCK_EN
    check("loss_lock_fail", 32'(lock_fail), 0);
    check("loss_retry", 32'(retry_cnt), 0);
    pulse_len(n);
    check("loss_relock_pulse", 32'(n), 4);
    pll_locked = 1'b1;
    k = cyc + 1;
    wait_release(e);
    check("loss_relock_release", 32'(e - k), 10);
`else
    check("loss_lock_fail", 32'(lock_fail), 1);
    check("loss_pll_rst", 32'(pll_rst), 0);
    pll_locked = 1'b1;
    tick(20);
    check("fail_sticky", 32'(lock_fail), 1);
    check("fail_sys_rst", 32'(sys_rst), 1);
`endif

    // Lock glitch in STABLE after one retry
    do_reset();
    pulse_len(n);
    wait_pll_rst_high(ok);
    check("glitch_retry_pulse_seen", 32'(ok), 1);
    pulse_len(n);
    check("glitch_retry_pulse_len", 32'(n), 4);
    check("glitch_retry_before", 32'(retry_cnt), 1);
    pll_locked = 1'b1;
    k = cyc + 1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    j = cyc + 1;
    check("glitch_first_lock_edge", 32'(j - k), 7);
    check("glitch_retry_mid", 32'(retry_cnt), 1);
    tick(4);
    check("glitch_sys_rst_mid", 32'(sys_rst), 1);
    check("glitch_retry_wait", 32'(retry_cnt), 1);
    wait_release(e);
    check("glitch_release_edge", 32'(e - j), 10);
    check("glitch_retry_run", 32'(retry_cnt), 0);

    // Reset while in WAIT_LOCK with a retry consumed
    do_reset();
    tick(80);
    check("rwl_retry_pre", 32'(retry_cnt), 1);
    check("rwl_pll_rst_pre", 32'(pll_rst), 0);
    rst = 1'b1;
    tick(1);
    check("rwl_pll_rst", 32'(pll_rst), 1);
    check("rwl_sys_rst", 32'(sys_rst), 1);
    check("rwl_retry", 32'(retry_cnt), 0);
    check("rwl_lock_fail", 32'(lock_fail), 0);

    // Exhausted retries: lock never arrives
    do_reset();
    rel = cyc;
    pulses = 1;
    prev = pll_rst;
    maxr = 0;
    fe = -1;
    for (int i = 1; i <= 210; i++) begin
      tick(1);
      if (pll_rst === 1'b1 && prev === 1'b0) pulses++;
      prev = pll_rst;
      if (int'(retry_cnt) > maxr) maxr = int'(retry_cnt);
      if (lock_fail === 1'b1 && fe < 0) fe = cyc - rel;
    end
    check("exh_pulses", 32'(pulses), 3);
    check("exh_max_retry", 32'(maxr), 2);
    check("exh_fail_edge", 32'(fe), 204);
    check("exh_fail_persist", 32'(lock_fail), 1);
    check("exh_sys_rst", 32'(sys_rst), 1);
    check("exh_pll_rst", 32'(pll_rst), 0);

    // Reset while in FAIL
    rst = 1'b1;
    tick(1);
    check("rf_lock_fail", 32'(lock_fail), 0);
    check("rf_pll_rst", 32'(pll_rst), 1);
    check("rf_sys_rst", 32'(sys_rst), 1);
    check("rf_retry", 32'(retry_cnt), 0);
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
